// File: rtl/wb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    // Owner state for the master selected by a one-bit index.
    function automatic arb_state_t own_state(input logic idx);
        return idx ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Transfer watchdog: counts stalled strobe cycles and flags a one-cycle expiry on the terminal count.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] TERM = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_cnt;

    // A simultaneous clear (slave termination) always beats expiry.
    assign expire_o = run_i & ~clr_i & (r_cnt == TERM);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i | expire_o) begin
            r_cnt <= '0;
        end else if (run_i && (r_cnt != TERM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin grant, cycle lock and watchdog.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    output logic                busy_o
);

    localparam int unsigned SEL_W = DATA_W / 8;

    arb_state_t r_state;
    logic       r_last_owner;

    logic              w_req0;
    logic              w_req1;
    logic              w_grant;
    logic              w_term;
    logic              w_wd_err;
    logic              w_o_cyc;
    logic              w_o_stb;
    logic              w_o_we;
    logic [SEL_W-1:0]  w_o_sel;
    logic [ADDR_W-1:0] w_o_adr;
    logic [DATA_W-1:0] w_o_dat;
    logic              w_ack;
    logic              w_err;

    assign w_req0  = m0_cyc_i & m0_stb_i;
    assign w_req1  = m1_cyc_i & m1_stb_i;
    assign w_grant = (r_state == ARB_IDLE) & (w_req0 | w_req1);
    assign w_term  = s_ack_i | s_err_i;

    // Request mux: everything reads zero while idle.
    always_comb begin
        w_o_cyc = 1'b0;
        w_o_stb = 1'b0;
        w_o_we  = 1'b0;
        w_o_sel = '0;
        w_o_adr = '0;
        w_o_dat = '0;
        unique case (r_state)
            ARB_OWN0: begin
                w_o_cyc = m0_cyc_i;
                w_o_stb = m0_stb_i;
                w_o_we  = m0_we_i;
                w_o_sel = m0_sel_i;
                w_o_adr = m0_adr_i;
                w_o_dat = m0_dat_i;
            end
            ARB_OWN1: begin
                w_o_cyc = m1_cyc_i;
                w_o_stb = m1_stb_i;
                w_o_we  = m1_we_i;
                w_o_sel = m1_sel_i;
                w_o_adr = m1_adr_i;
                w_o_dat = m1_dat_i;
            end
            default: begin
            end
        endcase
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_grant | w_term | ~w_o_stb),
        .run_i    (w_o_stb),
        .expire_o (w_wd_err)
    );

    // Slave terminations only count while the owner is strobing.
    assign w_ack = w_o_stb & s_ack_i;
    assign w_err = (w_o_stb & s_err_i) | w_wd_err;

    assign s_cyc_o = w_o_cyc;
    assign s_stb_o = w_o_stb & ~w_wd_err;
    assign s_we_o  = w_o_we;
    assign s_sel_o = w_o_sel;
    assign s_adr_o = w_o_adr;
    assign s_dat_o = w_o_dat;

    assign m0_ack_o = (r_state == ARB_OWN0) & w_ack;
    assign m0_err_o = (r_state == ARB_OWN0) & w_err;
    assign m1_ack_o = (r_state == ARB_OWN1) & w_ack;
    assign m1_err_o = (r_state == ARB_OWN1) & w_err;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign busy_o   = (r_state != ARB_IDLE);

    // On a tie the master that did not own last wins; reset pointer favours m0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ARB_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_req0 & (~w_req1 | r_last_owner)) begin
                        r_state <= own_state(1'b0);
                    end else if (w_req1) begin
                        r_state <= own_state(1'b1);
                    end
                end
                ARB_OWN0: begin
                    if (!m0_cyc_i) begin
                        r_state      <= ARB_IDLE;
                        r_last_owner <= 1'b0;
                    end
                end
                ARB_OWN1: begin
                    if (!m1_cyc_i) begin
                        r_state      <= ARB_IDLE;
                        r_last_owner <= 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
